// File: rtl/arith_unit_arbiter.sv
// Round-robin arbiter sharing one registered INC/DEC unit among NREQ requesters.
// Optional ARB_FLAGS_EN adds registered flag_zero / flag_wrap outputs.
module arith_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*WIDTH-1:0]  operand,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [WIDTH-1:0]       result,
  output logic [WIDTH-1:0]       unit_inp,
  output logic                   unit_op,
  input  logic [WIDTH-1:0]       unit_out
`ifdef ARB_FLAGS_EN
  ,
  output logic                   flag_zero,
  output logic                   flag_wrap
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  unit_inp_q, unit_inp_d;
  logic              unit_op_q, unit_op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              capture;
`ifdef ARB_FLAGS_EN
  logic              flag_zero_q, flag_zero_d;
  logic              flag_wrap_q, flag_wrap_d;
`endif

  // First set request scanning ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    int unsigned j;
    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!pick_valid && req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  assign capture = (state_q == S_WAIT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential blocks use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs; combinational blocks use blocking.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_WAIT;
      S_WAIT:  if (capture)    state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    gnt_d      = gnt_q;
    done_d     = '0;
    result_d   = result_q;
    unit_inp_d = unit_inp_q;
    unit_op_d  = unit_op_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
`ifdef ARB_FLAGS_EN
    flag_zero_d = flag_zero_q;
    flag_wrap_d = flag_wrap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          unit_inp_d      = operand[pick_idx*WIDTH +: WIDTH];
          unit_op_d       = op[pick_idx];
          cnt_d           = CW'(LAT);
          idx_d           = pick_idx;
        end
      end
      S_WAIT: begin
        if (capture) begin
          result_d      = unit_out;
          done_d[idx_q] = 1'b1;
`ifdef ARB_FLAGS_EN
          flag_zero_d = (unit_out == '0);
          flag_wrap_d = (!unit_op_q && (unit_inp_q == '0)) ||
                        ( unit_op_q && (unit_inp_q == '1));
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        gnt_d = '0;
        ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      unit_inp_q <= '0;
      unit_op_q  <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
`ifdef ARB_FLAGS_EN
      flag_zero_q <= 1'b0;
      flag_wrap_q <= 1'b0;
`endif
    end else begin
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      unit_inp_q <= unit_inp_d;
      unit_op_q  <= unit_op_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
`ifdef ARB_FLAGS_EN
      flag_zero_q <= flag_zero_d;
      flag_wrap_q <= flag_wrap_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign result   = result_q;
  assign unit_inp = unit_inp_q;
  assign unit_op  = unit_op_q;
`ifdef ARB_FLAGS_EN
  assign flag_zero = flag_zero_q;
  assign flag_wrap = flag_wrap_q;
`endif

endmodule
